hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Drives the Write/Flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus PC write enable and PC source select.
- Detects load-use hazards, branch/jump redirects and data-memory wait states via a ready handshake.
- Keeps a wait-timeout FSM and saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, consecutive frozen cycles in MEM_WAIT before entering ERROR (valid range 1..255).
- CNT_W, 32, width of the stall and flush performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- ifid_rs  in  5  rs field of the instruction in ID
- ifid_rt  in  5  rt field of the instruction in ID
- idex_memread  in  1  instruction in EX is a load
- idex_rt  in  5  destination rt of the instruction in EX
- branch_taken_ex  in  1  branch in EX resolved taken
- jump_id  in  1  j/jal/jr/jalr decoded in ID
- exmem_memread  in  1  EX/MEM holds a load
- exmem_memwrite  in  1  EX/MEM holds a store
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC register enable
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
- ifid_write, ifid_flush  out  1 each  IF/ID controls
- idex_write, idex_flush  out  1 each  ID/EX controls
- exmem_write, exmem_flush  out  1 each  EX/MEM controls
- memwb_write, memwb_flush  out  1 each  MEM/WB controls
- mem_error  out  1  sticky memory-timeout flag
- stall_count  out  CNT_W  cycles stalled (load-use or memory freeze)
- flush_count  out  CNT_W  cycles in which a redirect flush was issued

Behaviour:
- Reset: synchronous, active-high on clk rising edge. state=RUN, wait_cnt=0, mem_error=0, stall_count=0, flush_count=0.
- While reset is high, the combinational outputs are: all *_write=1, all *_flush=0, pc_write=1, pc_src=00.
- Control outputs are combinational from the current state and inputs (same-cycle effect). Counters and mem_error are registered.
- Derived terms:
  - mem_op = exmem_memread | exmem_memwrite
  - freeze = mem_op & ~dmem_ready
  - load_use = idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt)
- Priority, highest first:
  - ERROR state: pc_write=0, all *_write=0, memwb_flush=1, all other flushes 0. No counters change. Held until reset.
  - freeze: pc_write=0; ifid/idex/exmem_write=0; memwb_flush=1 (bubble into WB); branch/jump ignored.
  - branch_taken_ex: pc_src=01, pc_write=1, ifid_flush=1, idex_flush=1. Overrides load_use and jump_id.
  - load_use: pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble per hazard. jump_id is ignored this cycle and re-evaluated next cycle.
  - jump_id: pc_src=10, pc_write=1, ifid_flush=1.
  - Otherwise: pc_src=00, all writes 1, all flushes 0.
- Flush is asserted together with write=1 on the same stage; pipeline registers give flush priority.
- FSM states:
  - RUN: freeze -> MEM_WAIT with wait_cnt=1. Else stay.
  - MEM_WAIT: dmem_ready=1 -> RUN with wait_cnt=0; the ready cycle itself behaves as RUN (no freeze). Else, if wait_cnt==MEM_TIMEOUT -> ERROR with mem_error<=1. Else wait_cnt+1.
  - ERROR: absorbing until reset.
- Counters, saturating at all-ones (no wrap):
  - stall_count +1 each cycle in which freeze or load_use is the active priority.
  - flush_count +1 each cycle in which branch or jump redirect is active.
- A mem_op with dmem_ready=1 in the same cycle causes no stall, no state change, and no counter increment.
- Reset asserted in MEM_WAIT or ERROR returns to RUN on the next edge, and clears mem_error and both counters.

Test Plan:
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1; stall_count goes 0->1. With idex_rt=0, no stall.
- Branch over load-use: branch_taken_ex=1 and load_use both true -> pc_src=01, ifid_flush=1, idex_flush=1, pc_write=1; flush_count=1, stall_count unchanged.
- Memory wait: exmem_memread=1, dmem_ready=0 for 3 cycles, then 1 -> freeze for 3 cycles (memwb_flush=1, exmem_write=0), release on the 4th cycle; state returns to RUN; stall_count=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_error=1 after the 5th frozen edge; outputs stay frozen after dmem_ready rises; reset clears mem_error and returns to RUN.
- Jump: jump_id=1 with no other hazard -> pc_src=10, ifid_flush=1, idex_flush=0; jump_id with freeze -> frozen, flush_count unchanged.
- Saturation: CNT_W=4, 20 load-use cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Hazard-detection inputs and pipeline-register control outputs of the
// hazard control unit. The pipeline datapath is the master side; the hazard
// control unit is the slave side.
interface hazard_control_unit_if;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       idex_memread;
    logic [4:0] idex_rt;
    logic       branch_taken_ex;
    logic       jump_id;
    logic       exmem_memread;
    logic       exmem_memwrite;
    logic       dmem_ready;

    logic       pc_write;
    logic [1:0] pc_src;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_write;
    logic       idex_flush;
    logic       exmem_write;
    logic       exmem_flush;
    logic       memwb_write;
    logic       memwb_flush;

    modport master (
        output ifid_rs, ifid_rt, idex_memread, idex_rt, branch_taken_ex,
               jump_id, exmem_memread, exmem_memwrite, dmem_ready,
        input  pc_write, pc_src, ifid_write, ifid_flush, idex_write,
               idex_flush, exmem_write, exmem_flush, memwb_write, memwb_flush
    );

    modport slave (
        input  ifid_rs, ifid_rt, idex_memread, idex_rt, branch_taken_ex,
               jump_id, exmem_memread, exmem_memwrite, dmem_ready,
        output pc_write, pc_src, ifid_write, ifid_flush, idex_write,
               idex_flush, exmem_write, exmem_flush, memwb_write, memwb_flush
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use
// bubbles, branch/jump redirects, data-memory freeze with timeout, and
// saturating stall/flush performance counters.
module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_control_unit_if.slave hz,
    output logic                 mem_error,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

    state_t     state;
    logic [7:0] wait_cnt;

    logic mem_op;
    logic freeze;
    logic load_use;
    logic stall_evt;
    logic flush_evt;

    // Hazard terms derived from the current pipeline contents
    always_comb begin
        mem_op   = hz.exmem_memread | hz.exmem_memwrite;
        freeze   = mem_op & ~hz.dmem_ready;
        load_use = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                   ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));
    end

    // Prioritised pipeline controls; the ready cycle in MEM_WAIT has no
    // freeze so it naturally falls through to the RUN behaviour
    always_comb begin
        hz.pc_write    = 1'b1;
        hz.pc_src      = 2'b00;
        hz.ifid_write  = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_write  = 1'b1;
        hz.idex_flush  = 1'b0;
        hz.exmem_write = 1'b1;
        hz.exmem_flush = 1'b0;
        hz.memwb_write = 1'b1;
        hz.memwb_flush = 1'b0;
        stall_evt      = 1'b0;
        flush_evt      = 1'b0;
        if (reset) begin
            // defaults hold while reset is asserted
        end else if (state == ERROR) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
            hz.memwb_write = 1'b0;
            hz.memwb_flush = 1'b1;
        end else if (freeze) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
            hz.memwb_flush = 1'b1;
            stall_evt      = 1'b1;
        end else if (hz.branch_taken_ex) begin
            hz.pc_src      = 2'b01;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            flush_evt      = 1'b1;
        end else if (load_use) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_flush  = 1'b1;
            stall_evt      = 1'b1;
        end else if (hz.jump_id) begin
            hz.pc_src      = 2'b10;
            hz.ifid_flush  = 1'b1;
            flush_evt      = 1'b1;
        end
    end

    // Wait-timeout FSM, sticky error flag and saturating counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_error   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (hz.dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TIMEOUT_V) begin
                        state     <= ERROR;
                        mem_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= RUN;
                end
            endcase

            if (stall_evt && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (flush_evt && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule
